// File: rtl/uart_pkg.sv
// uart_pkg: state encodings and sizing helpers shared by the UART tx/rx pair.
package uart_pkg;
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    function automatic int baud_ticks(input int clk_hz, input int bit_rate);
        return clk_hz / bit_rate;
    endfunction

    function automatic int cnt_w(input int n);
        return $clog2(n) + 1;
    endfunction
endpackage

// File: rtl/uart_tx_if.sv
// uart_tx_if: byte producer handshake plus enable and frame-done pulse.
interface uart_tx_if #(parameter int PAYLOAD_BITS = 8);
    logic                    uart_tx_en;
    logic [PAYLOAD_BITS-1:0] uart_tx_data;
    logic                    uart_tx_valid;
    logic                    uart_tx_ready;
    logic                    uart_tx_done;
    modport master (output uart_tx_en, uart_tx_data, uart_tx_valid, input uart_tx_ready, uart_tx_done);
    modport slave  (input uart_tx_en, uart_tx_data, uart_tx_valid, output uart_tx_ready, uart_tx_done);
endinterface

// File: rtl/uart_baud_cnt.sv
// uart_baud_cnt: loadable down-counter with zero flag; holds at zero until reloaded.
module uart_baud_cnt #(parameter int W = 4) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         load,
    input  logic         dec,
    input  logic [W-1:0] load_val,
    output logic         zero
);
    logic [W-1:0] cnt;
    assign zero = cnt == '0;
    always_ff @(posedge clk or negedge resetn)
        if (!resetn) cnt <= '0;
        else if (load) cnt <= load_val;
        else if (dec && !zero) cnt <= cnt - 1'b1;
endmodule

// File: rtl/uart_tx.sv
// uart_tx: serialises bytes onto uart_txd as start/data(LSB first)/[parity]/stop frames.
// Define UART_TX_PARITY_EN to insert an even-parity bit after the payload.
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLK_HZ       = 50_000_000,
    parameter int BIT_RATE     = 9600,
    parameter int PAYLOAD_BITS = 8,
    parameter int STOP_BITS    = 1
) (
    input  logic     clk,
    input  logic     resetn,
    uart_tx_if.slave bus,
    output logic     uart_txd
);
    localparam int BT     = baud_ticks(CLK_HZ, BIT_RATE);
    localparam int BAUD_W = cnt_w(BT);
    localparam int BIT_W  = cnt_w(PAYLOAD_BITS);

    logic [2:0]              state;
    logic [PAYLOAD_BITS-1:0] shift;
    logic [BIT_W-1:0]        bit_cnt;
    logic                    baud_zero, busy, accept, bit_end, frame_end, last_data, last_stop;
`ifdef UART_TX_PARITY_EN
    logic                    par;
`endif

    assign busy      = state != S_IDLE;
    assign accept    = !busy && bus.uart_tx_ready && bus.uart_tx_valid;
    assign bit_end   = busy && baud_zero;
    assign last_data = bit_cnt == BIT_W'(PAYLOAD_BITS - 1);
    assign last_stop = bit_cnt == BIT_W'(STOP_BITS - 1);
    assign frame_end = bit_end && state == S_STOP && last_stop;

    uart_baud_cnt #(.W(BAUD_W)) u_baud (
        .clk      (clk),
        .resetn   (resetn),
        .load     (accept || (bit_end && !frame_end)),
        .dec      (busy),
        .load_val (BAUD_W'(BT - 1)),
        .zero     (baud_zero)
    );

    // uart_txd is registered, so each branch drives the level of the bit being entered
    always_ff @(posedge clk or negedge resetn)
        if (!resetn) begin
            state              <= S_IDLE;
            shift              <= '0;
            bit_cnt            <= '0;
            uart_txd           <= 1'b1;
            bus.uart_tx_ready  <= 1'b0;
            bus.uart_tx_done   <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par                <= 1'b0;
`endif
        end else begin
            bus.uart_tx_done  <= frame_end;
            bus.uart_tx_ready <= bus.uart_tx_en && (frame_end || (!busy && !accept));
            if (accept) begin
                state    <= S_START;
                shift    <= bus.uart_tx_data;
                uart_txd <= 1'b0;
`ifdef UART_TX_PARITY_EN
                par      <= ^bus.uart_tx_data;
`endif
            end else if (bit_end) begin
                case (state)
                    S_START: begin
                        state    <= S_DATA;
                        bit_cnt  <= '0;
                        uart_txd <= shift[0];
                    end
                    S_DATA: begin
                        if (last_data) begin
`ifdef UART_TX_PARITY_EN
                            state    <= S_PARITY;
                            uart_txd <= par;
`else
                            state    <= S_STOP;
                            bit_cnt  <= '0;
                            uart_txd <= 1'b1;
`endif
                        end else begin
                            bit_cnt  <= bit_cnt + 1'b1;
                            shift    <= shift >> 1;
                            uart_txd <= shift[1];
                        end
                    end
`ifdef UART_TX_PARITY_EN
                    S_PARITY: begin
                        state    <= S_STOP;
                        bit_cnt  <= '0;
                        uart_txd <= 1'b1;
                    end
`endif
                    S_STOP: begin
                        if (last_stop) state <= S_IDLE;
                        else bit_cnt <= bit_cnt + 1'b1;
                    end
                    default: begin
                        state    <= S_IDLE;
                        uart_txd <= 1'b1;
                    end
                endcase
            end
        end
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed frame vectors plus handshake, enable and reset corner sequences for uart_tx.
module tb_uart_tx;
    localparam int BT = 10;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int FL = NB * BT;

    typedef struct {
        logic [7:0] d;
        logic [0:7] db;
        logic       p;
    } vec_t;

    logic clk = 1'b0;
    logic resetn;
    logic txd;
    int   checks = 0;
    int   failures = 0;
    vec_t vecs [8];

    uart_tx_if #(.PAYLOAD_BITS(8)) bus ();

    uart_tx #(.CLK_HZ(1_000_000), .BIT_RATE(100_000), .PAYLOAD_BITS(8), .STOP_BITS(1)) dut (
        .clk      (clk),
        .resetn   (resetn),
        .bus      (bus.slave),
        .uart_txd (txd)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0t actual=%b expected=%b", name, $time, act, exp);
        end
    endtask

    function automatic logic exp_bit(input logic [0:7] db, input logic p, input int k);
        int idx;
        idx = k / BT;
        if (idx == 0) return 1'b0;
        if (idx <= 8) return db[idx-1];
        if (NB == 11 && idx == 9) return p;
        return 1'b1;
    endfunction

    // called at a negedge; returns #1 after the accepting edge
    task automatic start_frame(input logic [7:0] d, input logic [7:0] next_d, input bit hold);
        int n;
        n = 0;
        bus.uart_tx_data  = d;
        bus.uart_tx_valid = 1'b1;
        while (!bus.uart_tx_ready && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (!bus.uart_tx_ready) begin
            chk("ready_timeout", 1'b0, 1'b1);
            bus.uart_tx_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        if (hold) bus.uart_tx_data = next_d;
        else bus.uart_tx_valid = 1'b0;
    endtask

    task automatic check_bits(input logic [0:7] db, input logic p, input logic exp_rdy, input int drop_at);
        for (int k = 0; k < FL; k++) begin
            @(negedge clk);
            chk("txd_bit", txd, exp_bit(db, p, k));
            chk("done_early", bus.uart_tx_done, 1'b0);
            if (k > 0) chk("ready_busy", bus.uart_tx_ready, 1'b0);
            if (k == drop_at) begin
                bus.uart_tx_en    = 1'b0;
                bus.uart_tx_valid = 1'b1;
                bus.uart_tx_data  = 8'h81;
            end
        end
        @(negedge clk);
        chk("done_pulse", bus.uart_tx_done, 1'b1);
        chk("txd_idle", txd, 1'b1);
        chk("ready_after", bus.uart_tx_ready, exp_rdy);
    endtask

    initial begin
        vecs[0] = '{8'hA5, 8'b1010_0101, 1'b0};
        vecs[1] = '{8'h3C, 8'b0011_1100, 1'b0};
        vecs[2] = '{8'h55, 8'b1010_1010, 1'b0};
        vecs[3] = '{8'h00, 8'b0000_0000, 1'b0};
        vecs[4] = '{8'hFF, 8'b1111_1111, 1'b0};
        vecs[5] = '{8'h81, 8'b1000_0001, 1'b0};
        vecs[6] = '{8'h07, 8'b1110_0000, 1'b1};
        vecs[7] = '{8'h03, 8'b1100_0000, 1'b0};

        resetn            = 1'b0;
        bus.uart_tx_en    = 1'b1;
        bus.uart_tx_valid = 1'b0;
        bus.uart_tx_data  = 8'h00;
        repeat (5) @(negedge clk);
        chk("rst_txd", txd, 1'b1);
        chk("rst_ready", bus.uart_tx_ready, 1'b0);
        chk("rst_done", bus.uart_tx_done, 1'b0);
        resetn = 1'b1;
        #1 chk("ready_before_edge", bus.uart_tx_ready, 1'b0);
        @(negedge clk);
        chk("ready_after_release", bus.uart_tx_ready, 1'b1);

        for (int i = 0; i < 8; i++) begin
            start_frame(vecs[i].d, 8'h00, 1'b0);
            check_bits(vecs[i].db, vecs[i].p, 1'b1, -1);
            @(negedge clk);
            chk("done_one_cycle", bus.uart_tx_done, 1'b0);
        end

        // back-to-back with valid held; data change after accept must be ignored
        start_frame(8'h00, 8'hFF, 1'b1);
        check_bits(8'b0000_0000, 1'b0, 1'b1, -1);
        @(posedge clk);
        #1 bus.uart_tx_valid = 1'b0;
        check_bits(8'b1111_1111, 1'b0, 1'b1, -1);
        @(negedge clk);
        chk("b2b_done_one_cycle", bus.uart_tx_done, 1'b0);

        // enable dropped mid-frame with a new byte pending
        start_frame(8'h3C, 8'h00, 1'b0);
        check_bits(8'b0011_1100, 1'b0, 1'b0, 30);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            chk("en_off_ready", bus.uart_tx_ready, 1'b0);
            chk("en_off_txd", txd, 1'b1);
            chk("en_off_done", bus.uart_tx_done, 1'b0);
        end
        bus.uart_tx_en = 1'b1;
        start_frame(8'h81, 8'h00, 1'b0);
        check_bits(8'b1000_0001, 1'b0, 1'b1, -1);
        @(negedge clk);

        // async reset during data bit 3 (cycle 45) of 8'hA5
        start_frame(8'hA5, 8'h00, 1'b0);
        for (int k = 0; k < 45; k++) begin
            @(negedge clk);
            chk("pre_rst_txd", txd, exp_bit(8'b1010_0101, 1'b0, k));
        end
        @(negedge clk);
        chk("pre_rst_low", txd, 1'b0);
        resetn = 1'b0;
        #1;
        chk("mid_rst_txd", txd, 1'b1);
        chk("mid_rst_ready", bus.uart_tx_ready, 1'b0);
        chk("mid_rst_done", bus.uart_tx_done, 1'b0);
        repeat (3) begin
            @(negedge clk);
            chk("rst_hold_done", bus.uart_tx_done, 1'b0);
        end
        resetn = 1'b1;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            chk("post_rst_no_done", bus.uart_tx_done, 1'b0);
            chk("post_rst_txd", txd, 1'b1);
        end
        start_frame(8'h55, 8'h00, 1'b0);
        check_bits(8'b1010_1010, 1'b0, 1'b1, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
